// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: dispatch into the lowest free slot, snoop
// CDB broadcasts to wake pending operands, and issue the oldest ready entry
// into a registered execute output with valid/ready backpressure.
module rs_age_ordered #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 8,
  localparam int unsigned CNT_W  = $clog2(SIZE + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        disp_valid_i,
  output logic                        disp_ready_o,
  input  logic [OP_W-1:0]             disp_op_i,
  input  logic [DATA_W-1:0]           disp_vj_i,
  input  logic [DATA_W-1:0]           disp_vk_i,
  input  logic [TAG_W-1:0]            disp_qj_i,
  input  logic [TAG_W-1:0]            disp_qk_i,
  input  logic                        disp_qj_valid_i,
  input  logic                        disp_qk_valid_i,
  input  logic [TAG_W-1:0]            disp_dest_i,
  input  logic [DATA_W-1:0]           disp_imm_i,
  input  logic [DATA_W-1:0]           disp_pc_i,
  input  logic [DATA_W-1:0]           disp_pred_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_value_i,
  output logic                        ex_valid_o,
  input  logic                        ex_ready_i,
  output logic [OP_W-1:0]             ex_op_o,
  output logic [DATA_W-1:0]           ex_vj_o,
  output logic [DATA_W-1:0]           ex_vk_o,
  output logic [DATA_W-1:0]           ex_imm_o,
  output logic [DATA_W-1:0]           ex_pc_o,
  output logic [DATA_W-1:0]           ex_pred_o,
  output logic [TAG_W-1:0]            ex_dest_o,
  output logic [CNT_W-1:0]            count_o
);

  localparam int unsigned IDX_W = $clog2(SIZE);

  // Control state (reset)
  logic [SIZE-1:0]  busy_q, busy_d;
  logic [SIZE-1:0]  qj_v_q, qj_v_d, qk_v_q, qk_v_d;
  // older_q[i][j] set: entry j was dispatched before entry i
  logic [SIZE-1:0]  older_q [SIZE];
  logic [SIZE-1:0]  older_d [SIZE];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]  ex_op_q;

  // Entry payload (no reset; only meaningful while busy)
  logic [OP_W-1:0]   op_q   [SIZE];
  logic [DATA_W-1:0] vj_q   [SIZE];
  logic [DATA_W-1:0] vk_q   [SIZE];
  logic [TAG_W-1:0]  qj_q   [SIZE];
  logic [TAG_W-1:0]  qk_q   [SIZE];
  logic [TAG_W-1:0]  dest_q [SIZE];
  logic [DATA_W-1:0] imm_q  [SIZE];
  logic [DATA_W-1:0] pc_q   [SIZE];
  logic [DATA_W-1:0] pred_q [SIZE];

  logic [DATA_W-1:0] ex_vj_q, ex_vk_q, ex_imm_q, ex_pc_q, ex_pred_q;
  logic [TAG_W-1:0]  ex_dest_q;

  logic [SIZE-1:0]   wk_j, wk_k, ready, sel;
  logic [DATA_W-1:0] wk_j_val [SIZE];
  logic [DATA_W-1:0] wk_k_val [SIZE];
  logic              dj_hit, dk_hit;
  logic [DATA_W-1:0] dj_val, dk_val;
  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic              disp_fire, issue;

  assign disp_ready_o = (count_q < CNT_W'(SIZE));
  assign disp_fire    = disp_valid_i && disp_ready_o && !flush_i;
  assign ready        = busy_q & ~qj_v_q & ~qk_v_q;
  assign issue        = (|ready) && (!ex_valid_q || ex_ready_i) && !flush_i;

  // CDB snoop for resident entries and the incoming dispatch; lowest port wins
  always_comb begin
    wk_j   = '0;
    wk_k   = '0;
    dj_hit = 1'b0;
    dk_hit = 1'b0;
    dj_val = '0;
    dk_val = '0;
    for (int i = 0; i < SIZE; i++) begin
      wk_j_val[i] = '0;
      wk_k_val[i] = '0;
    end
    for (int p = 0; p < NUM_CDB; p++) begin
      for (int i = 0; i < SIZE; i++) begin
        if (cdb_valid_i[p] && busy_q[i] && qj_v_q[i] && !wk_j[i] &&
            qj_q[i] == cdb_tag_i[p*TAG_W +: TAG_W]) begin
          wk_j[i]     = 1'b1;
          wk_j_val[i] = cdb_value_i[p*DATA_W +: DATA_W];
        end
        if (cdb_valid_i[p] && busy_q[i] && qk_v_q[i] && !wk_k[i] &&
            qk_q[i] == cdb_tag_i[p*TAG_W +: TAG_W]) begin
          wk_k[i]     = 1'b1;
          wk_k_val[i] = cdb_value_i[p*DATA_W +: DATA_W];
        end
      end
      if (cdb_valid_i[p] && disp_qj_valid_i && !dj_hit &&
          disp_qj_i == cdb_tag_i[p*TAG_W +: TAG_W]) begin
        dj_hit = 1'b1;
        dj_val = cdb_value_i[p*DATA_W +: DATA_W];
      end
      if (cdb_valid_i[p] && disp_qk_valid_i && !dk_hit &&
          disp_qk_i == cdb_tag_i[p*TAG_W +: TAG_W]) begin
        dk_hit = 1'b1;
        dk_val = cdb_value_i[p*DATA_W +: DATA_W];
      end
    end
  end

  // Lowest free slot for dispatch, oldest ready entry for issue
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < SIZE; i++) begin
      sel[i] = ready[i] && !(|(older_q[i] & ready));
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  // Next-state for occupancy, pending flags, age matrix, count and ex_valid
  always_comb begin
    busy_d     = busy_q;
    qj_v_d     = qj_v_q & ~wk_j;
    qk_v_d     = qk_v_q & ~wk_k;
    older_d    = older_q;
    count_d    = count_q;
    ex_valid_d = ex_valid_q;
    if (flush_i) begin
      busy_d     = '0;
      qj_v_d     = '0;
      qk_v_d     = '0;
      count_d    = '0;
      ex_valid_d = 1'b0;
      for (int i = 0; i < SIZE; i++) older_d[i] = '0;
    end else begin
      if (issue) busy_d[sel_idx] = 1'b0;
      if (disp_fire) begin
        busy_d[free_idx] = 1'b1;
        qj_v_d[free_idx] = disp_qj_valid_i && !dj_hit;
        qk_v_d[free_idx] = disp_qk_valid_i && !dk_hit;
        // New entry is younger than everything; stale column bits are cleared
        for (int i = 0; i < SIZE; i++) older_d[i][free_idx] = 1'b0;
        older_d[free_idx] = busy_q;
      end
      if (issue)           ex_valid_d = 1'b1;
      else if (ex_ready_i) ex_valid_d = 1'b0;
      if (disp_fire && !issue)      count_d = count_q + CNT_W'(1);
      else if (!disp_fire && issue) count_d = count_q - CNT_W'(1);
    end
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      qj_v_q     <= '0;
      qk_v_q     <= '0;
      count_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      for (int i = 0; i < SIZE; i++) older_q[i] <= '0;
    end else begin
      busy_q     <= busy_d;
      qj_v_q     <= qj_v_d;
      qk_v_q     <= qk_v_d;
      count_q    <= count_d;
      ex_valid_q <= ex_valid_d;
      older_q    <= older_d;
      if (issue) ex_op_q <= op_q[sel_idx];
    end
  end

  // Entry payload capture, operand wakeup and execute payload load
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SIZE; i++) begin
      if (wk_j[i]) vj_q[i] <= wk_j_val[i];
      if (wk_k[i]) vk_q[i] <= wk_k_val[i];
    end
    if (disp_fire) begin
      op_q[free_idx]   <= disp_op_i;
      vj_q[free_idx]   <= dj_hit ? dj_val : disp_vj_i;
      vk_q[free_idx]   <= dk_hit ? dk_val : disp_vk_i;
      qj_q[free_idx]   <= disp_qj_i;
      qk_q[free_idx]   <= disp_qk_i;
      dest_q[free_idx] <= disp_dest_i;
      imm_q[free_idx]  <= disp_imm_i;
      pc_q[free_idx]   <= disp_pc_i;
      pred_q[free_idx] <= disp_pred_i;
    end
    if (issue) begin
      ex_vj_q   <= vj_q[sel_idx];
      ex_vk_q   <= vk_q[sel_idx];
      ex_imm_q  <= imm_q[sel_idx];
      ex_pc_q   <= pc_q[sel_idx];
      ex_pred_q <= pred_q[sel_idx];
      ex_dest_q <= dest_q[sel_idx];
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_op_o    = ex_op_q;
  assign ex_vj_o    = ex_vj_q;
  assign ex_vk_o    = ex_vk_q;
  assign ex_imm_o   = ex_imm_q;
  assign ex_pc_o    = ex_pc_q;
  assign ex_pred_o  = ex_pred_q;
  assign ex_dest_o  = ex_dest_q;
  assign count_o    = count_q;

endmodule
